// File: rtl/dft_stream_bins.sv
// Streaming N-point DFT: NCH bins starting at a runtime base bin, built up one
// sample per handshake through a lookup / multiply-round / accumulate pipeline.

module dft_bin_lane #(
    parameter int N    = 64,
    parameter int W    = 16,
    parameter int TW   = 16,
    parameter int LG   = 6,
    parameter int ACCW = W + 2 + LG
) (
    input  logic                   clk,
    input  logic                   sreset,
    input  logic                   clear,
    input  logic                   accept,
    input  logic                   v1,
    input  logic                   v2,
    input  logic                   inverse,
    input  logic [LG-1:0]          k,
    input  logic [N-1:0][TW-1:0]   cos_lut,
    input  logic [N-1:0][TW-1:0]   sin_lut,
    input  logic signed [W-1:0]    x1_re,
    input  logic signed [W-1:0]    x1_im,
    output logic signed [ACCW-1:0] acc_re,
    output logic signed [ACCW-1:0] acc_im
);
    localparam int MW = W + TW;
    localparam int PW = W + TW + 1;
    localparam int RW = W + 2;
    localparam logic signed [PW-1:0] HALF = PW'(1 << (TW - 2));

    logic [LG-1:0]        ph;
    logic signed [TW-1:0] c1, s1;
    logic signed [MW-1:0] xr_c, xi_s, xi_c, xr_s;
    logic signed [PW-1:0] p_re, p_im;
    logic signed [RW-1:0] q_re, q_im;

    assign xr_c = MW'(x1_re) * MW'(c1);
    assign xi_s = MW'(x1_im) * MW'(s1);
    assign xi_c = MW'(x1_im) * MW'(c1);
    assign xr_s = MW'(x1_re) * MW'(s1);

    // Forward multiplies by e^{-j}, inverse by e^{+j}: only the S terms flip sign.
    always_comb begin
        if (inverse) begin
            p_re = PW'(xr_c) - PW'(xi_s);
            p_im = PW'(xi_c) + PW'(xr_s);
        end else begin
            p_re = PW'(xr_c) + PW'(xi_s);
            p_im = PW'(xi_c) - PW'(xr_s);
        end
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            ph     <= '0;
            c1     <= '0;
            s1     <= '0;
            q_re   <= '0;
            q_im   <= '0;
            acc_re <= '0;
            acc_im <= '0;
        end else begin
            if (clear)       ph <= '0;
            else if (accept) ph <= ph + k;
            if (accept) begin
                c1 <= cos_lut[ph];
                s1 <= sin_lut[ph];
            end
            if (v1) begin
                q_re <= RW'((p_re + HALF) >>> (TW - 1));
                q_im <= RW'((p_im + HALF) >>> (TW - 1));
            end
            if (clear) begin
                acc_re <= '0;
                acc_im <= '0;
            end else if (v2) begin
                acc_re <= acc_re + ACCW'(q_re);
                acc_im <= acc_im + ACCW'(q_im);
            end
        end
    end
endmodule

module dft_stream_bins #(
    parameter  int N    = 64,
    parameter  int W    = 16,
    parameter  int TW   = 16,
    parameter  int NCH  = 8,
    localparam int LG   = $clog2(N),
    localparam int ACCW = W + 2 + LG
) (
    input  logic                       clk,
    input  logic                       sreset,
    input  logic                       start,
    input  logic                       inverse,
    input  logic [LG-1:0]              bin_base,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [W-1:0]        in_re,
    input  logic signed [W-1:0]        in_im,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NCH-1:0][ACCW-1:0]   out_re,
    output logic [NCH-1:0][ACCW-1:0]   out_im,
    output logic                       busy,
    output logic                       done
);
    localparam int STAGES = 3;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

    state_t               state_q, state_d;
    logic [STAGES:0]      vld_pipe;
    logic [STAGES:1]      vld_q;
    logic [LG-1:0]        n_q, base_q;
    logic                 inv_q, accept, start_acc;
    logic signed [W-1:0]  x1_re, x1_im;
    logic [N-1:0][TW-1:0] cos_lut, sin_lut;

    function automatic int twiddle(input int m, input bit use_sin);
        real ang, v;
        ang = 2.0 * 3.14159265358979323846 * real'(m) / real'(N);
        v   = (use_sin ? $sin(ang) : $cos(ang)) * (2.0 ** (TW - 1) - 1.0);
        return (v < 0.0) ? $rtoi(v - 0.5) : $rtoi(v + 0.5);
    endfunction

    for (genvar m = 0; m < N; m++) begin : g_lut
        localparam int CQ = twiddle(m, 1'b0);
        localparam int SQ = twiddle(m, 1'b1);
        assign cos_lut[m] = CQ[TW-1:0];
        assign sin_lut[m] = SQ[TW-1:0];
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign accept    = in_valid && in_ready;
    assign start_acc = start && (state_q == IDLE);
    assign vld_pipe  = {vld_q, accept};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (accept && n_q == LG'(N - 1)) state_d = DRAIN;
            // Last sample has left the accumulator once only the final stage is valid.
            DRAIN:   if (vld_pipe[STAGES:1] == 3'b100) state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q <= IDLE;
            vld_q   <= '0;
            n_q     <= '0;
            base_q  <= '0;
            inv_q   <= 1'b0;
            x1_re   <= '0;
            x1_im   <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_pipe[STAGES-1:0];
            done    <= out_valid && out_ready;
            if (start_acc) begin
                n_q    <= '0;
                base_q <= bin_base;
                inv_q  <= inverse;
            end else if (accept) begin
                n_q <= n_q + 1'b1;
            end
            if (accept) begin
                x1_re <= in_re;
                x1_im <= in_im;
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        dft_bin_lane #(.N(N), .W(W), .TW(TW), .LG(LG), .ACCW(ACCW)) u_lane (
            .clk     (clk),
            .sreset  (sreset),
            .clear   (start_acc),
            .accept  (accept),
            .v1      (vld_pipe[1]),
            .v2      (vld_pipe[2]),
            .inverse (inv_q),
            .k       (base_q + LG'(c)),
            .cos_lut (cos_lut),
            .sin_lut (sin_lut),
            .x1_re   (x1_re),
            .x1_im   (x1_im),
            .acc_re  (out_re[c]),
            .acc_im  (out_im[c])
        );
    end
endmodule

// File: tb/tb_dft_stream_bins.sv
// Directed bench for dft_stream_bins: the driver queues expected bins per frame,
// a negedge monitor pops and compares whenever results are presented.
`timescale 1ns/1ps
module tb_dft_stream_bins;
    localparam int  N = 64, W = 16, TW = 16, NCH = 8, LG = 6, ACCW = W + 2 + LG;
    localparam real PI = 3.14159265358979323846;

    logic clk = 0, sreset = 1, start = 0, inverse = 0, in_valid = 0, out_ready = 1;
    logic [LG-1:0] bin_base = '0;
    logic signed [W-1:0] in_re = '0, in_im = '0;
    logic in_ready, out_valid, busy, done;
    logic [NCH-1:0][ACCW-1:0] out_re, out_im, snap_re, snap_im;

    always #5 clk = ~clk;

    dft_stream_bins #(.N(N), .W(W), .TW(TW), .NCH(NCH)) dut (
        .clk(clk), .sreset(sreset), .start(start), .inverse(inverse), .bin_base(bin_base),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [NCH-1:0][31:0] re;
        logic [NCH-1:0][31:0] im;
        logic [NCH-1:0][15:0] tol;
    } exp_t;

    exp_t sb_q[$];
    exp_t e, x;
    int checks = 0, errors = 0, cyc = 0, last_acc = 0, frame_no = 0, done_st = 0;
    bit prev_ov = 0;
    int xr[N], xi[N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v, input int tol);
        checks++;
        if (act - exp_v > tol || exp_v - act > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (+/-%0d)", nm, act, exp_v, tol);
        end
    endtask

    task automatic abort(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out", nm);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    function automatic int rnd(input real v);
        return (v < 0.0) ? $rtoi(v - 0.5) : $rtoi(v + 0.5);
    endfunction

    function automatic void set_all(input int re, input int im, input int tol);
        for (int c = 0; c < NCH; c++) begin
            e.re[c] = re; e.im[c] = im; e.tol[c] = 16'(tol);
        end
    endfunction

    function automatic void set_ch(input int c, input int re, input int im, input int tol);
        e.re[c] = re; e.im[c] = im; e.tol[c] = 16'(tol);
    endfunction

    function automatic void load(input int kind);
        for (int n = 0; n < N; n++) begin
            xr[n] = 0; xi[n] = 0;
            if (kind == 1) xr[n] = 100;
            if (kind == 2) begin
                xr[n] = rnd(1000.0 * $cos(2.0 * PI * 5.0 * real'(n) / 64.0));
                xi[n] = rnd(1000.0 * $sin(2.0 * PI * 5.0 * real'(n) / 64.0));
            end
        end
        if (kind == 0) xr[0] = 1000;
        if (kind == 3) xr[16] = 800;
    endfunction

    // x[16]=800 lands on quarter-turn twiddles: bins cycle (800,0),(0,-800),(-800,0),(0,800).
    function automatic void exp_x16();
        for (int c = 0; c < NCH; c++)
            case (c % 4)
                0: set_ch(c, 800, 0, 0);
                1: set_ch(c, 0, -800, 0);
                2: set_ch(c, -800, 0, 0);
                default: set_ch(c, 0, 800, 0);
            endcase
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_frame(input logic inv, input int base);
        inverse = inv; bin_base = LG'(base); start = 1;
        tick();
        start = 0;
        @(negedge clk);
        chk("start->busy", int'(busy), 1, 0);
        chk("start->in_ready", int'(in_ready), 1, 0);
        tick();
    endtask

    task automatic send(input int re, input int im);
        bit ok = 0;
        in_valid = 1; in_re = W'(re); in_im = W'(im);
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) abort("in_ready wait");
        last_acc = cyc;
        tick();
        in_valid = 0; in_re = W'($urandom); in_im = W'($urandom);
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int t = 0; t < 50 && !idle; t++) begin
            @(negedge clk);
            idle = !busy;
        end
        if (!idle) abort("idle wait");
        tick();
    endtask

    task automatic run(input logic inv, input int base, input int gap, input int hold);
        bit seen = 0;
        sb_q.push_back(e);
        if (hold > 0) out_ready = 0;
        start_frame(inv, base);
        for (int n = 0; n < N; n++) begin
            repeat ($urandom_range(gap, 0)) tick();
            send(xr[n], xi[n]);
        end
        if (hold > 0) begin
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                seen = out_valid;
            end
            if (!seen) abort("out_valid wait");
            repeat (hold) tick();
            out_ready = 1;
        end
        wait_idle();
    endtask

    always @(negedge clk) begin
        if (sreset) begin
            prev_ov = 0;
            done_st = 0;
        end else begin
            if (done_st == 1) begin
                chk("done pulse", int'(done), 1, 0);
                chk("idle after handshake", int'(out_valid || busy), 0, 0);
                done_st = 2;
            end else if (done_st == 2) begin
                chk("done single cycle", int'(done), 0, 0);
                done_st = 0;
            end
            if (out_valid) begin
                if (!prev_ov) begin
                    chk("out latency", cyc - last_acc, 4, 0);
                    snap_re = out_re;
                    snap_im = out_im;
                end else begin
                    chk("out stable", int'(out_re == snap_re && out_im == snap_im), 1, 0);
                end
                if (out_ready) begin
                    if (sb_q.size() == 0) chk("unexpected output", 1, 0, 0);
                    else begin
                        x = sb_q.pop_front();
                        for (int c = 0; c < NCH; c++) begin
                            chk($sformatf("frame%0d ch%0d re", frame_no, c),
                                int'($signed(out_re[c])), int'($signed(x.re[c])), int'(x.tol[c]));
                            chk($sformatf("frame%0d ch%0d im", frame_no, c),
                                int'($signed(out_im[c])), int'($signed(x.im[c])), int'(x.tol[c]));
                        end
                        frame_no++;
                    end
                    done_st = 1;
                end
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        repeat (3) tick();
        @(negedge clk);
        chk("rst in_ready", int'(in_ready), 0, 0);
        chk("rst out_valid", int'(out_valid), 0, 0);
        chk("rst busy", int'(busy), 0, 0);
        chk("rst done", int'(done), 0, 0);
        chk("rst out zero", int'(out_re != '0 || out_im != '0), 0, 0);
        sreset = 0;
        tick();

        load(0); set_all(1000, 0, 0);                        run(0, 0, 0, 0);
        load(1); set_all(0, 0, 64); set_ch(0, 6400, 0, 0);   run(0, 0, 0, 0);
        set_all(0, 0, 64); set_ch(4, 6400, 0, 0);            run(0, 60, 0, 0);
        load(2); set_all(0, 0, 64); set_ch(5, 64000, 0, 64); run(0, 0, 0, 0);
        set_all(0, 0, 64);                                   run(0, 60, 0, 0);
        set_all(0, 0, 64); set_ch(3, 64000, 0, 64);          run(1, 56, 0, 0);
        set_all(0, 0, 64);                                   run(1, 0, 0, 0);
        set_all(0, 0, 64); set_ch(5, 64000, 0, 64);          run(0, 0, 3, 10);
        load(3); exp_x16();                                  run(0, 0, 3, 10);

        // A start mid-frame with a different base and direction must change nothing.
        exp_x16();
        sb_q.push_back(e);
        start_frame(0, 0);
        for (int n = 0; n < N; n++) begin
            if (n == 10) begin
                start = 1; inverse = 1; bin_base = LG'(5);
                tick();
                start = 0;
            end
            send(xr[n], xi[n]);
        end
        wait_idle();

        load(0);
        start_frame(0, 0);
        for (int n = 0; n <= 30; n++) send(xr[n], xi[n]);
        sreset = 1;
        tick();
        sreset = 0;
        @(negedge clk);
        chk("mid rst in_ready", int'(in_ready), 0, 0);
        chk("mid rst busy", int'(busy), 0, 0);
        chk("mid rst out_valid", int'(out_valid), 0, 0);
        chk("mid rst out zero", int'(out_re != '0 || out_im != '0), 0, 0);
        tick();

        set_all(1000, 0, 0); run(0, 0, 0, 0);

        for (int t = 0; t < 100 && sb_q.size() != 0; t++) @(negedge clk);
        chk("scoreboard drained", sb_q.size(), 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
